// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CPU_OWN = 2'd1,
    DMA_OWN = 2'd2
  } arb_state_t;

  localparam logic [3:0] LANE_B = 4'b0001;
  localparam logic [3:0] LANE_H = 4'b0011;
  localparam logic [3:0] LANE_W = 4'b1111;

  localparam int STARVE_MAX_DEF = 4;
  localparam int STARVE_W       = $clog2(STARVE_MAX_DEF + 1);

endpackage

// File: rtl/dmem_load_format.sv
// CPU load formatting: per-lane masking of the array word plus optional
// sign extension of byte and halfword loads.
module dmem_load_format
  import dmem_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [3:0]  re,
  input  logic        sext,
  output logic [31:0] data
);

  logic [31:0] masked;

  // keep only the requested lanes, then extend the top kept bit for partial loads
  always_comb begin
    masked = 32'h0000_0000;
    for (int j = 0; j < 4; j++) begin
      if (re[j]) begin
        masked[8*j +: 8] = raw[8*j +: 8];
      end else begin
        masked[8*j +: 8] = 8'h00;
      end
    end
    data = masked;
    if (sext && (re == LANE_B)) begin
      data[31:8] = {24{masked[7]}};
    end else if (sext && (re == LANE_H)) begin
      data[31:16] = {16{masked[15]}};
    end else begin
      data = masked;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester (CPU MEM stage / DMA port) arbiter for the byte-addressed data
// memory. Optional perf counters are enabled with `define DMEM_ARB_PERF_EN.
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = 7,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [3:0]        cpu_we,
  input  logic [3:0]        cpu_re,
  input  logic              cpu_sext,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_stall,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_last,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [15:0]       perf_cpu_stall_cnt,
  output logic [15:0]       perf_dma_beats
`endif
);

  // wait counters are never narrower than the default configuration needs
  localparam int WAIT_W = ($clog2(STARVE_MAX + 1) > STARVE_W) ? $clog2(STARVE_MAX + 1) : STARVE_W;
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_MAX);

  arb_state_t        state_q, state_d;
  logic [WAIT_W-1:0] dma_wait_q, dma_wait_d;
  logic [WAIT_W-1:0] cpu_wait_q, cpu_wait_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic              dma_rvalid_q, dma_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dma_rdata_q, dma_rdata_d;
  logic [31:0]       cpu_fmt;
  logic              dma_starved;
  logic              cpu_starved;

  assign dma_starved = (dma_wait_q == WAIT_MAX);
  assign cpu_starved = (cpu_wait_q == WAIT_MAX);

  dmem_load_format u_fmt (
    .raw  (mem_rdata),
    .re   (cpu_re),
    .sext (cpu_sext),
    .data (cpu_fmt)
  );

  // grant decision and next ownership; a granted dma_last beat ends DMA ownership
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    state_d = state_q;
    if (reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (cpu_req) begin
            cpu_gnt = 1'b1;
          end else if (dma_req) begin
            dma_gnt = 1'b1;
          end else begin
            cpu_gnt = 1'b0;
          end
        end
        CPU_OWN: begin
          if (cpu_req) begin
            if (dma_req && dma_starved) begin
              dma_gnt = 1'b1;
            end else begin
              cpu_gnt = 1'b1;
            end
          end else if (dma_req) begin
            dma_gnt = 1'b1;
          end else begin
            dma_gnt = 1'b0;
          end
        end
        DMA_OWN: begin
          if (dma_req) begin
            if (cpu_req && cpu_starved) begin
              cpu_gnt = 1'b1;
            end else begin
              dma_gnt = 1'b1;
            end
          end else begin
            dma_gnt = 1'b0;
          end
        end
        default: begin
          cpu_gnt = 1'b0;
          dma_gnt = 1'b0;
        end
      endcase

      if (dma_gnt) begin
        state_d = dma_last ? (cpu_req ? CPU_OWN : IDLE) : DMA_OWN;
      end else if (cpu_gnt) begin
        state_d = (state_q == DMA_OWN) ? DMA_OWN : CPU_OWN;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // starvation counters: count denied cycles of a live request, clear otherwise
  always_comb begin
    dma_wait_d = '0;
    cpu_wait_d = '0;
    if (reset) begin
      dma_wait_d = '0;
      cpu_wait_d = '0;
    end else begin
      if (dma_req && !dma_gnt) begin
        dma_wait_d = dma_starved ? WAIT_MAX : dma_wait_q + WAIT_W'(1);
      end else begin
        dma_wait_d = '0;
      end
      if (cpu_req && !cpu_gnt) begin
        cpu_wait_d = cpu_starved ? WAIT_MAX : cpu_wait_q + WAIT_W'(1);
      end else begin
        cpu_wait_d = '0;
      end
    end
  end

  assign cpu_stall = cpu_req & ~cpu_gnt;

  // steer the granted requester onto the array port
  always_comb begin
    mem_addr  = cpu_addr;
    mem_wdata = cpu_wdata;
    mem_we    = 4'b0000;
    if (cpu_gnt) begin
      mem_we = cpu_we;
    end else if (dma_gnt) begin
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
      mem_we    = dma_we ? LANE_W : 4'b0000;
    end else begin
      mem_we = 4'b0000;
    end
  end

  // read data is captured at the grant edge; stores and DMA writes give no rvalid
  always_comb begin
    cpu_rvalid_d = cpu_gnt && (cpu_re != 4'b0000);
    dma_rvalid_d = dma_gnt && !dma_we;
    cpu_rdata_d  = cpu_rdata_q;
    dma_rdata_d  = dma_rdata_q;
    if (cpu_rvalid_d) begin
      cpu_rdata_d = DATA_W'(cpu_fmt);
    end else begin
      cpu_rdata_d = cpu_rdata_q;
    end
    if (dma_rvalid_d) begin
      dma_rdata_d = mem_rdata;
    end else begin
      dma_rdata_d = dma_rdata_q;
    end
  end

  // state, counters and read registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      dma_wait_q   <= '0;
      cpu_wait_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      dma_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      dma_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      dma_wait_q   <= dma_wait_d;
      cpu_wait_q   <= cpu_wait_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      dma_rvalid_q <= dma_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dma_rdata_q  <= dma_rdata_d;
    end
  end

  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign dma_rvalid = dma_rvalid_q;
  assign dma_rdata  = dma_rdata_q;

`ifdef DMEM_ARB_PERF_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;
  logic [15:0] beats_q, beats_d;

  // saturating event counters
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    beats_d     = beats_q;
    if (cpu_stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_d = stall_cnt_q + 16'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    if (dma_gnt && (beats_q != 16'hFFFF)) begin
      beats_d = beats_q + 16'd1;
    end else begin
      beats_d = beats_q;
    end
  end

  // perf counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      beats_q     <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      beats_q     <= beats_d;
    end
  end

  assign perf_cpu_stall_cnt = stall_cnt_q;
  assign perf_dma_beats     = beats_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed steps followed by random
// traffic, compared against a cycle-level behavioural model and a byte array.
module tb_dmem_arbiter;

  localparam int AW   = 7;
  localparam int DW   = 32;
  localparam int SMAX = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_sext, cpu_gnt, cpu_stall, cpu_rvalid;
  logic [AW-1:0] cpu_addr;
  logic [3:0]    cpu_we, cpu_re;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dma_req, dma_last, dma_we, dma_gnt, dma_rvalid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata, dma_rdata;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef DMEM_ARB_PERF_EN
  logic [15:0]   perf_cpu_stall_cnt, perf_dma_beats;
`endif

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_sext(cpu_sext), .cpu_wdata(cpu_wdata), .cpu_gnt(cpu_gnt),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_last(dma_last), .dma_addr(dma_addr), .dma_we(dma_we),
    .dma_wdata(dma_wdata), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid),
    .dma_rdata(dma_rdata), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef DMEM_ARB_PERF_EN
    , .perf_cpu_stall_cnt(perf_cpu_stall_cnt), .perf_dma_beats(perf_dma_beats)
`endif
  );

  // memory array (big-endian: byte at base lands in bits 31:24)
  logic [7:0] arr [0:127];
  logic       tb_init;

  function automatic logic [7:0] init_byte(input int i);
    return 8'((i * 37 + 5) & 255);
  endfunction

  always @(posedge clk) begin
    if (tb_init) begin
      for (int i = 0; i < 128; i++) arr[i] <= init_byte(i);
    end else begin
      for (int k = 0; k < 4; k++)
        if (mem_we[k]) arr[7'(mem_addr + 7'(k))] <= mem_wdata[8*(3-k) +: 8];
    end
  end

  always_comb mem_rdata = {arr[mem_addr], arr[mem_addr + 7'd1], arr[mem_addr + 7'd2], arr[mem_addr + 7'd3]};

  // reference model
  logic [7:0]  ref_mem [0:127];
  int          m_own;          // 0 none, 1 cpu, 2 dma
  int          m_dw, m_cw;
  logic        m_crv, m_drv;
  logic [31:0] m_crd, m_drd;
  logic        obs_cg, obs_dg, obs_st;
  int          n_tests = 0;
  int          n_fail  = 0;

  logic [6:0]  baddr [3] = '{7'h7E, 7'h02, 7'h06};
  logic [31:0] bdata [3] = '{32'hA1B2C3D4, 32'h01020304, 32'h05060708};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_word(input logic [6:0] a);
    logic [31:0] v = 32'd0;
    for (int j = 0; j < 4; j++) v = (v << 8) | 32'(ref_mem[7'(a + 7'(j))]);
    return v;
  endfunction

  function automatic logic [31:0] ref_load(input logic [6:0] a, input logic [3:0] re, input logic sx);
    logic [31:0] w = ref_word(a);
    logic [31:0] v = 32'd0;
    for (int j = 0; j < 4; j++)
      if (re[j]) v = v | (w & (32'hFF << (8 * j)));
    if (sx && re == 4'b0001 && v[7])  v = v | 32'hFFFFFF00;
    if (sx && re == 4'b0011 && v[15]) v = v | 32'hFFFF0000;
    return v;
  endfunction

  task automatic cycle(input logic c, input logic [6:0] ca, input logic [3:0] cwe,
                       input logic [3:0] cre, input logic cs, input logic [31:0] cwd,
                       input logic d, input logic dl, input logic [6:0] da,
                       input logic dwe, input logic [31:0] dwd);
    logic eg_c, eg_d, n_crv, n_drv;
    logic [3:0] ewe;
    cpu_req = c; cpu_addr = ca; cpu_we = cwe; cpu_re = cre; cpu_sext = cs; cpu_wdata = cwd;
    dma_req = d; dma_last = dl; dma_addr = da; dma_we = dwe; dma_wdata = dwd;
    eg_c = 1'b0; eg_d = 1'b0;
    case (m_own)
      0:       if (c) eg_c = 1'b1; else if (d) eg_d = 1'b1;
      1:       if (c && !(d && m_dw == SMAX)) eg_c = 1'b1; else if (d) eg_d = 1'b1;
      default: if (d) begin if (c && m_cw == SMAX) eg_c = 1'b1; else eg_d = 1'b1; end
    endcase
    ewe = eg_c ? cwe : ((eg_d && dwe) ? 4'hF : 4'h0);
    #2;
    obs_cg = cpu_gnt; obs_dg = dma_gnt; obs_st = cpu_stall;
    check("cpu_gnt", cpu_gnt, eg_c);
    check("dma_gnt", dma_gnt, eg_d);
    check("cpu_stall", cpu_stall, c & ~eg_c);
    check("mem_we", mem_we, ewe);
    if (eg_c || eg_d) check("mem_addr", mem_addr, eg_c ? ca : da);
    check("cpu_rvalid", cpu_rvalid, m_crv);
    check("dma_rvalid", dma_rvalid, m_drv);
    if (m_crv) check("cpu_rdata", cpu_rdata, m_crd);
    if (m_drv) check("dma_rdata", dma_rdata, m_drd);
    n_crv = eg_c && (cre != 4'b0000);
    n_drv = eg_d && !dwe;
    if (n_crv) m_crd = ref_load(ca, cre, cs);
    if (n_drv) m_drd = ref_word(da);
    if (eg_c)
      for (int k = 0; k < 4; k++) if (cwe[k]) ref_mem[7'(ca + 7'(k))] = cwd[8*(3-k) +: 8];
    if (eg_d && dwe)
      for (int k = 0; k < 4; k++) ref_mem[7'(da + 7'(k))] = dwd[8*(3-k) +: 8];
    if (eg_d)      m_own = dl ? (c ? 1 : 0) : 2;
    else if (eg_c) m_own = (m_own == 2) ? 2 : 1;
    else           m_own = 0;
    m_dw = (d && !eg_d) ? ((m_dw < SMAX) ? m_dw + 1 : m_dw) : 0;
    m_cw = (c && !eg_c) ? ((m_cw < SMAX) ? m_cw + 1 : m_cw) : 0;
    @(posedge clk); #1;
    m_crv = n_crv; m_drv = n_drv;
  endtask

  task automatic cpu_ld(input logic [6:0] a, input logic [3:0] re, input logic sx);
    cycle(1'b1, a, 4'h0, re, sx, 32'd0, 1'b0, 1'b0, 7'd0, 1'b0, 32'd0);
  endtask

  task automatic dma_wr(input logic [6:0] a, input logic [31:0] wd, input logic last);
    cycle(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 32'd0, 1'b1, last, a, 1'b1, wd);
  endtask

  task automatic idle();
    cycle(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 32'd0, 1'b0, 1'b0, 7'd0, 1'b0, 32'd0);
  endtask

  // hold reset with whatever requests are currently driven
  task automatic do_reset();
    reset = 1'b1;
    #2;
    check("rst_cpu_gnt_comb", cpu_gnt, 1'b0);
    check("rst_dma_gnt_comb", dma_gnt, 1'b0);
    check("rst_mem_we_comb", mem_we, 4'h0);
    @(posedge clk); #1;
    check("rst_cpu_rvalid", cpu_rvalid, 1'b0);
    check("rst_dma_rvalid", dma_rvalid, 1'b0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_rdata", dma_rdata, 32'd0);
    check("rst_cpu_gnt", cpu_gnt, 1'b0);
    check("rst_dma_gnt", dma_gnt, 1'b0);
    reset = 1'b0;
    cpu_req = 1'b0; dma_req = 1'b0; dma_last = 1'b0;
    m_own = 0; m_dw = 0; m_cw = 0; m_crv = 1'b0; m_drv = 1'b0;
  endtask

  initial begin
    logic [4:0]  dg_hist, st_hist;
    logic [7:0]  p20, p21;
    int          first_cg, tries, diffs;
    logic        c, d, ld;
    logic [3:0]  cre, cwe;

    reset = 1'b1; tb_init = 1'b1;
    cpu_req = 1'b0; cpu_addr = '0; cpu_we = '0; cpu_re = '0; cpu_sext = 1'b0; cpu_wdata = '0;
    dma_req = 1'b0; dma_last = 1'b0; dma_addr = '0; dma_we = 1'b0; dma_wdata = '0;
    for (int i = 0; i < 128; i++) ref_mem[i] = init_byte(i);
    @(posedge clk); #1;
    tb_init = 1'b0;
    do_reset();

    // word and partial loads
    dma_wr(7'h10, 32'h11223344, 1'b1);
    cpu_ld(7'h10, 4'hF, 1'b0);
    check("ld_word_gnt", obs_cg, 1'b1);
    check("ld_word_stall", obs_st, 1'b0);
    check("ld_word_rvalid", cpu_rvalid, 1'b1);
    check("ld_word_data", cpu_rdata, 32'h11223344);
    dma_wr(7'h1C, 32'h00000080, 1'b1);
    cpu_ld(7'h1C, 4'b0001, 1'b1);
    check("ld_byte_sext", cpu_rdata, 32'hFFFFFF80);
    cpu_ld(7'h1C, 4'b0001, 1'b0);
    check("ld_byte_zext", cpu_rdata, 32'h00000080);
    dma_wr(7'h1C, 32'h00007FFF, 1'b1);
    cpu_ld(7'h1C, 4'b0011, 1'b1);
    check("ld_half_sext", cpu_rdata, 32'h00007FFF);

    // DMA starved by continuous CPU traffic
    idle();
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 7'h30, 4'h0, 4'hF, 1'b0, 32'd0, 1'b1, 1'b0, 7'h40, 1'b0, 32'd0);
      dg_hist[i] = obs_dg; st_hist[i] = obs_st;
    end
    check("starve_dma_gnt_hist", dg_hist, 5'b10000);
    check("starve_stall_hist", st_hist, 5'b10000);
    idle(); idle(); idle();

    // 3-beat write burst across the wrap point, CPU joins on beat 2
    for (int b = 0; b < 3; b++) begin
      tries = 0;
      do begin
        cycle(b > 0, 7'h50, 4'h0, 4'hF, 1'b0, 32'd0, 1'b1, b == 2, baddr[b], 1'b1, bdata[b]);
        tries++;
      end while (!obs_dg && tries < 20);
      check("burst_beat_gnt", obs_dg, 1'b1);
    end
    idle();
    check("wrap_7e", arr[7'h7E], 8'hA1);
    check("wrap_7f", arr[7'h7F], 8'hB2);
    check("wrap_00", arr[7'h00], 8'hC3);
    check("wrap_01", arr[7'h01], 8'hD4);
    check("beat2_02", arr[7'h02], 8'h01);
    check("beat3_09", arr[7'h09], 8'h08);

    // long DMA read burst starves the CPU, which then gets one slot
    idle();
    cycle(1'b0, 7'd0, 4'h0, 4'h0, 1'b0, 32'd0, 1'b1, 1'b0, 7'h08, 1'b0, 32'd0);
    first_cg = -1;
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 7'h60, 4'h0, 4'hF, 1'b0, 32'd0, 1'b1, 1'b0, 7'(8 + 4 * i), 1'b0, 32'd0);
      if (obs_cg && first_cg < 0) first_cg = i;
    end
    check("cpu_starve_first_gnt", first_cg, 4);
    tries = 0;
    do begin
      cycle(1'b1, 7'h60, 4'h0, 4'hF, 1'b0, 32'd0, 1'b1, 1'b1, 7'h70, 1'b0, 32'd0);
      tries++;
    end while (!obs_dg && tries < 20);
    check("burst_end_gnt", obs_dg, 1'b1);

    // partial store
    p20 = arr[7'h20]; p21 = arr[7'h21];
    cycle(1'b1, 7'h20, 4'b1100, 4'h0, 1'b0, 32'hAABBCCDD, 1'b0, 1'b0, 7'd0, 1'b0, 32'd0);
    check("st_gnt", obs_cg, 1'b1);
    check("st_no_rvalid", cpu_rvalid, 1'b0);
    check("st_b22", arr[7'h22], 8'hCC);
    check("st_b23", arr[7'h23], 8'hDD);
    check("st_b20_kept", arr[7'h20], p20);
    check("st_b21_kept", arr[7'h21], p21);

    // reset in the middle of a DMA burst
    idle();
    dma_wr(7'h60, 32'h12345678, 1'b0);
    cpu_req = 1'b1; dma_req = 1'b1;
    do_reset();
    cpu_ld(7'h10, 4'hF, 1'b0);
    check("post_rst_gnt", obs_cg, 1'b1);
    check("post_rst_stall", obs_st, 1'b0);
    check("post_rst_data", cpu_rdata, 32'h11223344);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      c   = ($urandom_range(99) < 65);
      d   = ($urandom_range(99) < 55);
      ld  = $urandom_range(1) == 1;
      case ($urandom_range(3))
        0:       cre = 4'b0001;
        1:       cre = 4'b0011;
        2:       cre = 4'b1111;
        default: cre = 4'($urandom_range(15, 1));
      endcase
      cwe = 4'($urandom_range(15, 1));
      cycle(c, 7'($urandom_range(127)), ld ? 4'h0 : cwe, ld ? cre : 4'h0, 1'($urandom_range(1)),
            $urandom, d, $urandom_range(99) < 30, 7'($urandom_range(127)),
            1'($urandom_range(1)), $urandom);
      if (i % 150 == 149) do_reset();
    end
    idle();

    diffs = 0;
    for (int i = 0; i < 128; i++) if (arr[i] !== ref_mem[i]) diffs++;
    check("mem_image_diffs", diffs, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters: the CPU MEM stage and a DMA/loader port that fills or dumps memory while the core runs.
- Grants at most one access per cycle.
- Raises cpu_stall when the MEM-stage access is not granted.
- Forms CPU load data, including byte-lane masking and sign extension.
- Sits between the pipeline's EX/MEM stage and the memory array.

Parameters:
- ADDR_W, 7, byte address width; memory depth is 2^ADDR_W bytes.
- DATA_W, 32, word width; fixed 4 byte lanes.
- STARVE_MAX, 4, cycles a requester may wait while the other owns memory before it is force-granted.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request (MEM stage valid with nonzero re or we mask)
- cpu_addr  in  ADDR_W  CPU byte base address
- cpu_we  in  4  CPU write lane mask; bit k writes wdata byte (3-k) to address addr+k
- cpu_re  in  4  CPU read lane mask; bit 0 = addr+3 into bits 7:0, bit 3 = addr into bits 31:24
- cpu_sext  in  1  sign-extend partial loads
- cpu_wdata  in  DATA_W  CPU store data
- cpu_gnt  out  1  CPU access performed this cycle
- cpu_stall  out  1  cpu_req and not cpu_gnt; freezes PC, IF/ID and MEM
- cpu_rvalid  out  1  CPU load data valid, one cycle after grant
- cpu_rdata  out  DATA_W  formatted CPU load data
- dma_req  in  1  DMA request
- dma_last  in  1  final beat of a DMA burst
- dma_addr  in  ADDR_W  DMA byte base address
- dma_we  in  1  DMA full-word write (0 = full-word read)
- dma_wdata  in  DATA_W  DMA write data
- dma_gnt  out  1  DMA beat performed this cycle
- dma_rvalid  out  1  DMA read data valid, one cycle after grant
- dma_rdata  out  DATA_W  raw word, no extension
- mem_addr  out  ADDR_W  base address to array
- mem_we  out  4  lane write enables
- mem_wdata  out  DATA_W  write data to array
- mem_rdata  in  DATA_W  combinational array read of 4 bytes at base (addr, addr+1, addr+2, addr+3 mod 2^ADDR_W)

Behaviour:
- FSM states: IDLE, CPU_OWN, DMA_OWN. Grant is combinational from state and requests; the memory write commits at the posedge where gnt is high.
- IDLE:
  - cpu_req: grant CPU, go to CPU_OWN.
  - Otherwise dma_req: grant DMA, go to DMA_OWN.
  - Both: CPU wins.
- CPU_OWN:
  - CPU keeps priority while cpu_req.
  - dma_wait counter increments each cycle dma_req is denied. At dma_wait == STARVE_MAX, the next cycle grants DMA, forces cpu_stall, clears dma_wait and goes to DMA_OWN.
  - cpu_req low: go to DMA_OWN if dma_req, else IDLE.
- DMA_OWN:
  - DMA holds ownership beat by beat until a granted beat with dma_last; then go to CPU_OWN if cpu_req, else IDLE.
  - cpu_wait counts denied CPU cycles. At cpu_wait == STARVE_MAX, the CPU is granted one cycle (DMA not granted) and cpu_wait clears. Ownership stays DMA_OWN.
  - dma_req dropped without dma_last: return to IDLE.
- Never both gnt high in one cycle. Grants are only issued to asserted requests.
- CPU grant drives mem_we = cpu_we. DMA write drives mem_we = 4'b1111; DMA read drives 4'b0000.
- Read path:
  - rdata is registered on grant; rvalid pulses one cycle later.
  - CPU lanes with re bit 0 are 0, unless cpu_sext: re == 0001 extends bit 7; re == 0011 extends bit 15.
  - A grant with re == 0 (store) gives no rvalid.
- Address wrap: modulo 2^ADDR_W, handled by the array. The arbiter passes the base address unmodified.
- Reset: state IDLE; both wait counters 0; all gnt, rvalid 0; rdata 0; mem_we 0. A reset mid-burst abandons the burst with no pending rvalid.
- cpu_stall is purely combinational, with no added latency.

Optional Feature:
- DMEM_ARB_PERF_EN defined: adds outputs perf_cpu_stall_cnt[15:0] (saturating count of cpu_stall cycles) and perf_dma_beats[15:0] (saturating count of DMA grants). Both clear on reset.
- Undefined: ports and counters are absent. Arbitration behaviour is identical either way.

Decomposition:
- Package dmem_pkg holds:
  - arb_state_t enum {IDLE, CPU_OWN, DMA_OWN}
  - lane mask constants LANE_B = 4'b0001, LANE_H = 4'b0011, LANE_W = 4'b1111
  - STARVE_W = $clog2(STARVE_MAX+1)
- Sub-module dmem_load_format (combinational): lane masking and sign extension of mem_rdata per re and sext.

Test Plan:
- CPU-only load at addr 0x10, re = 1111, array 11 22 33 44: cpu_gnt same cycle, cpu_stall 0; next cycle cpu_rvalid with 0x11223344.
- CPU byte load with re = 0001, sext = 1, byte 0x80 at addr+3: rdata 0xFFFFFF80. With sext = 0: 0x00000080. With re = 0011, sext = 1, bytes 0x7F 0xFF: 0x00007FFF.
- Simultaneous cpu_req and dma_req from IDLE: CPU granted, dma_gnt 0. With continuous cpu_req, DMA is denied STARVE_MAX = 4 cycles, then granted on the 5th with cpu_stall = 1 that cycle.
- DMA 3-beat write burst at addr 0x7E (dma_last on beat 3), cpu_req asserted mid-burst: CPU stalls up to 4 cycles then gets a one-cycle grant. The burst completes in order; wrap is verified at bytes 0x7E, 0x7F, 0x00, 0x01.
- CPU store with we = 1100, wdata 0xAABBCCDD at 0x20: only bytes 0x22 and 0x23 written (0xCC, 0xDD); no rvalid.
- Reset asserted mid DMA burst: next cycle state IDLE, all gnt and rvalid 0. A CPU request is granted immediately after reset deasserts.
